pc_next_unit: RTL

- Fetch-stage program counter register with next-PC selection.
- Consumes the branch-taken decision (Branch AND Zero) produced in EX, plus jump controls from ID and the hazard unit's stall.
- Drives the instruction memory address, PC+4 to the IF/ID register, and a flush strobe to IF/ID.
- Keeps a saturating taken-branch counter and a sticky misalignment flag.

---
 rtl/pc_next_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: fetch-stage program counter with next-PC selection.
//
// Ports:
//   Clk          in   rising-edge clock
//   Reset        in   synchronous, active-high reset
//   PCWrite      in   1 = advance PC, 0 = stall (hold)
//   BranchTaken  in   EX branch decision (Branch & Zero)
//   BranchTarget in   EX branch target address
//   Jump         in   j/jal decoded in ID
//   JumpIndex    in   instr[25:0] of the ID instruction
//   JumpReg      in   jr decoded in ID
//   JumpRegAddr  in   forwarded rs value for jr
//   PC           out  current fetch address (register output)
//   PCPlus4      out  PC + 4, combinational
//   IF_Flush     out  squash IF/ID contents
//   Redirect     out  non-sequential PC load accepted this cycle
//   BranchCount  out  saturating count of taken branches
//   AlignErr     out  sticky: a misaligned target was accepted
module pc_next_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Jump,
  input  logic [25:0]      JumpIndex,
  input  logic             JumpReg,
  input  logic [31:0]      JumpRegAddr,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic             IF_Flush,
  output logic             Redirect,
  output logic [CNT_W-1:0] BranchCount,
  output logic             AlignErr
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_fcnt;
  logic [1:0]         w_fcnt_nxt;
  logic [31:0]        r_pc;
  logic [CNT_W-1:0]   r_bcnt;
  logic               r_align_err;

  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_jump_target;
  logic               w_br_acc;
  logic               w_jr_acc;
  logic               w_j_acc;
  logic               w_redirect;
  logic [31:0]        w_target;
  logic [31:0]        w_pc_nxt;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_jump_target = {w_pc_plus4[31:28], JumpIndex, 2'b00};

  // Branch from EX is older than anything in ID, so it wins even over a stall.
  // Every acceptance term is masked by Reset so nothing leaks out during reset.
  assign w_br_acc   = BranchTaken & ~Reset;
  assign w_jr_acc   = JumpReg & PCWrite & ~BranchTaken & ~Reset;
  assign w_j_acc    = Jump & ~JumpReg & PCWrite & ~BranchTaken & ~Reset;
  assign w_redirect = w_br_acc | w_jr_acc | w_j_acc;

  always_comb begin
    w_target = w_jump_target;
    if (w_br_acc)
      w_target = BranchTarget;
    else if (w_jr_acc)
      w_target = JumpRegAddr;
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redirect)
      w_pc_nxt = {w_target[31:2], 2'b00};
    else if (PCWrite)
      w_pc_nxt = w_pc_plus4;
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc        <= RESET_PC;
      r_bcnt      <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_br_acc && (r_bcnt != '1))
        r_bcnt <= r_bcnt + 1'b1;
      if (w_redirect && (w_target[1:0] != 2'b00))
        r_align_err <= 1'b1;
    end
  end

  // Flush FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Flush FSM: next state. The redirect cycle itself is the first flush
  // cycle, so FLUSH only covers the remaining FLUSH_CYCLES-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      ST_RUN: begin
        if (w_redirect && (FLUSH_CYCLES > 1)) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = FCNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (w_redirect) begin
          w_fcnt_nxt = FCNT_LOAD;
        end else if (r_fcnt == 2'd1) begin
          w_state_nxt = ST_RUN;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt = r_fcnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  // Flush FSM: outputs
  always_comb begin
    Redirect = w_redirect;
    IF_Flush = w_redirect | ((r_state == ST_FLUSH) & ~Reset);
  end

  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign BranchCount = r_bcnt;
  assign AlignErr    = r_align_err;

endmodule
